scan_test_ctrl: RTL and testbench
=================================

# scan_test_ctrl

Scan-test sequencer for a full-scan DFT core whose state flip-flops have been cut into pseudo-primary inputs (PPI) and pseudo-primary outputs (PPO). The block owns the scan-chain registers that drive the PPIs. For each pattern it:

- shifts in a pattern,
- applies primary inputs and captures PPOs and POs in one functional cycle,
- shifts the response out,
- compares it against expected values and keeps a fail counter.

It sits between the test host (pattern source / result sink) and the combinational core under test.

## Interface
Parameters:
- CHAIN_LEN, 2, number of scan cells (PPI/PPO pairs)
- PI_W, 1, primary-input width
- PO_W, 1, primary-output width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pattern request; accepted only in IDLE
- pattern  in  CHAIN_LEN  scan-in value, sampled with accepted start
- pi_value  in  PI_W  primary-input value, sampled with accepted start
- exp_ppo  in  CHAIN_LEN  expected captured PPO, sampled with accepted start
- exp_po  in  PO_W  expected captured PO, sampled with accepted start
- clr_count  in  1  synchronous clear of fail_count
- ppi  out  CHAIN_LEN  scan-chain contents, drives the core PPIs
- pi  out  PI_W  primary inputs to the core
- ppo  in  CHAIN_LEN  core PPOs
- po  in  PO_W  core POs
- scan_en  out  1  high in SHIFT_IN / SHIFT_OUT
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse in COMPARE
- pass  out  1  valid with done, held until next done
- response  out  CHAIN_LEN  unloaded PPO response, valid with done
- fail_count  out  16  failing patterns, saturating

## Operation
- FSM states and transitions:
  - IDLE -> SHIFT_IN on start.
  - SHIFT_IN, CHAIN_LEN cycles -> CAPTURE.
  - CAPTURE, 1 cycle -> SHIFT_OUT.
  - SHIFT_OUT, CHAIN_LEN cycles -> COMPARE.
  - COMPARE, 1 cycle -> IDLE.
- Shift cycle counter: $clog2(CHAIN_LEN+1) bits, cleared on every state entry.
- Shift-in:
  - chain <= {chain[N-2:0], pattern_q[N-1-cnt]}, i.e. MSB first.
  - After CHAIN_LEN shifts, chain == pattern_q.
- Capture:
  - chain <= ppo; po_q <= po; scan_en = 0.
  - pi is driven with pi_value_q. It holds that value from start until the next accepted start.
- Shift-out:
  - chain[N-1] shifts into resp_sr, LSB end, each cycle; chain fills with 0.
  - After CHAIN_LEN shifts, resp_sr == captured PPO.
- COMPARE:
  - pass = (resp_sr == exp_ppo_q) && (po_q == exp_po_q).
  - response <= resp_sr; done = 1.
  - On !pass, fail_count increments, saturating at 16'hFFFF.
- Boundary conditions:
  - start while busy: ignored, no side effects.
  - clr_count in the same cycle as a failing COMPARE: clear wins, fail_count = 0.
  - rst_n low at any time, including mid-shift: immediately IDLE and all registers 0.
- ppi = chain at all times. The core sees shifting values during SHIFT; only the CAPTURE cycle is functional.

## Timing
- Reset values: ppi=0, pi=0, scan_en=0, busy=0, done=0, pass=0, response=0, fail_count=0, state=IDLE.
- Cycle timeline, with start sampled high in IDLE at edge 0:
  - busy is high from edge 0.
  - SHIFT_IN occupies cycles 1..N.
  - CAPTURE is cycle N+1.
  - SHIFT_OUT occupies cycles N+2..2N+1.
  - COMPARE/done is cycle 2N+2; for N=2, that is 6 cycles after start.
- Back-to-back patterns: the next start is accepted in the cycle after COMPARE. Pattern period is 2N+3 cycles.
- Core path ppi/pi -> ppo/po must settle within one clk period (capture cycle).

## Structure
- Package dft_pkg holds:
  - state enum scan_state_t {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, COMPARE}
  - FAIL_CNT_W = 16
- Sub-module scan_chain(CHAIN_LEN) holds the chain register:
  - inputs: shift_en, capture_en, scan_in, par_in
  - outputs: par_out, scan_out
- Top level holds the FSM, the counter, the sampled operands, the compare logic and the fail counter.

## Test plan
Bench core, N=2:
- ppo[1] = pi & (ppi[1] | ppi[0])
- ppo[0] = ~(ppi[1] | ppi[0])
- po = ~(ppo[1] | ppo[0])

Scenarios:
- pattern=2'b00, pi=1, exp_ppo=2'b01, exp_po=0 -> done at cycle 6, response=2'b01, pass=1, fail_count=0.
- pattern=2'b10, pi=1, exp_ppo=2'b10, exp_po=0 -> response=2'b10, pass=1; ppi==2'b10 during CAPTURE.
- pattern=2'b01, pi=0, exp_ppo=2'b00, exp_po=0 -> response=2'b00, po captured 1, pass=0, fail_count=1.
- start pulsed again at cycle 3 of a pattern -> ignored; exactly one done, no operand change.
- rst_n low during SHIFT_OUT -> busy=0, ppi=0, fail_count=0 immediately; next start runs a clean 6-cycle sequence.
- fail_count preloaded to 16'hFFFF via forced failures, then one more fail -> stays 16'hFFFF; clr_count with a failing COMPARE -> 0.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared types and constants for the scan-test sequencer.
//   scan_state_t : sequencer states, one pass per test pattern
//   FAIL_CNT_W   : width of the saturating fail counter
package dft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    COMPARE
  } scan_state_t;

  localparam int unsigned FAIL_CNT_W = 16;

endpackage

// File: rtl/scan_chain.sv
// Scan-chain register driving the core's pseudo-primary inputs.
// Shifts towards the MSB, with scan_in entering at bit 0 and scan_out taken
// from the MSB. A parallel load captures the core's PPOs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   shift_en    : shift one position (scan_in -> bit 0)
//   capture_en  : parallel load from par_in
//   scan_in     : serial input
//   par_in      : parallel capture data (core PPOs)
//   par_out     : chain contents (core PPIs)
//   scan_out    : serial output (chain MSB)
module scan_chain #(
  parameter int unsigned CHAIN_LEN = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_en,
  input  logic                 capture_en,
  input  logic                 scan_in,
  input  logic [CHAIN_LEN-1:0] par_in,
  output logic [CHAIN_LEN-1:0] par_out,
  output logic                 scan_out
);

  logic [CHAIN_LEN-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else if (capture_en) begin
      r_chain <= par_in;
    end else if (shift_en) begin
      // Size cast keeps this valid for a single-cell chain as well.
      r_chain <= (r_chain << 1) | CHAIN_LEN'(scan_in);
    end
  end

  assign par_out  = r_chain;
  assign scan_out = r_chain[CHAIN_LEN-1];

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: for each accepted pattern it shifts the pattern into
// the scan chain (MSB first), applies the primary inputs for one functional
// capture cycle, shifts the captured PPOs out, compares them (and the
// captured POs) against the expected values and counts failing patterns.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : pattern request, accepted only in IDLE
//   pattern, pi_value : scan-in value / primary inputs, sampled with start
//   exp_ppo, exp_po   : expected capture response, sampled with start
//   clr_count         : synchronous clear of fail_count (wins over increment)
//   ppi, pi           : drive the core under test
//   ppo, po           : core responses
//   scan_en, busy     : status
//   done, pass        : one-cycle result strobe; pass held until next done
//   response          : unloaded PPO response, valid with done
//   fail_count        : saturating count of failing patterns
module scan_test_ctrl
  import dft_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 2,
  parameter int unsigned PI_W      = 1,
  parameter int unsigned PO_W      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CHAIN_LEN-1:0]  pattern,
  input  logic [PI_W-1:0]       pi_value,
  input  logic [CHAIN_LEN-1:0]  exp_ppo,
  input  logic [PO_W-1:0]       exp_po,
  input  logic                  clr_count,
  output logic [CHAIN_LEN-1:0]  ppi,
  output logic [PI_W-1:0]       pi,
  input  logic [CHAIN_LEN-1:0]  ppo,
  input  logic [PO_W-1:0]       po,
  output logic                  scan_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CHAIN_LEN-1:0]  response,
  output logic [FAIL_CNT_W-1:0] fail_count
);

  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);

  scan_state_t r_state, w_state_next;

  logic [CW-1:0]         r_cnt;
  logic [CHAIN_LEN-1:0]  r_pattern_q;
  logic [PI_W-1:0]       r_pi_q;
  logic [CHAIN_LEN-1:0]  r_exp_ppo_q;
  logic [PO_W-1:0]       r_exp_po_q;
  logic [PO_W-1:0]       r_po_q;
  logic [CHAIN_LEN-1:0]  r_resp_sr;
  logic [CHAIN_LEN-1:0]  r_response;
  logic                  r_pass;
  logic [FAIL_CNT_W-1:0] r_fail_cnt;

  logic                  w_cnt_last;
  logic                  w_accept;
  logic                  w_scan_en;
  logic                  w_capture_en;
  logic                  w_scan_in;
  logic                  w_scan_out;
  logic [CHAIN_LEN-1:0]  w_chain;
  logic                  w_pass;

  assign w_cnt_last = (r_cnt == CW'(CHAIN_LEN - 1));
  assign w_accept   = (r_state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_scan_en    = 1'b0;
    w_capture_en = 1'b0;
    unique case (r_state)
      IDLE:      if (start) w_state_next = SHIFT_IN;
      SHIFT_IN: begin
        w_scan_en = 1'b1;
        if (w_cnt_last) w_state_next = CAPTURE;
      end
      CAPTURE: begin
        w_capture_en = 1'b1;
        w_state_next = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        w_scan_en = 1'b1;
        if (w_cnt_last) w_state_next = COMPARE;
      end
      COMPARE:   w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // Serial input selects pattern_q[N-1-cnt]; the chain fills with 0 on unload.
  always_comb begin
    w_scan_in = 1'b0;
    if (r_state == SHIFT_IN) begin
      for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
        if (CW'(CHAIN_LEN - 1 - i) == r_cnt) w_scan_in = r_pattern_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (w_state_next != r_state) r_cnt <= '0;
    else if (w_scan_en)               r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern_q <= '0;
      r_pi_q      <= '0;
      r_exp_ppo_q <= '0;
      r_exp_po_q  <= '0;
    end else if (w_accept) begin
      r_pattern_q <= pattern;
      r_pi_q      <= pi_value;
      r_exp_ppo_q <= exp_ppo;
      r_exp_po_q  <= exp_po;
    end
  end

  scan_chain #(.CHAIN_LEN(CHAIN_LEN)) u_chain (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (w_scan_en),
    .capture_en(w_capture_en),
    .scan_in   (w_scan_in),
    .par_in    (ppo),
    .par_out   (w_chain),
    .scan_out  (w_scan_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_po_q    <= '0;
      r_resp_sr <= '0;
    end else begin
      if (w_capture_en) r_po_q <= po;
      if (r_state == SHIFT_OUT)
        r_resp_sr <= (r_resp_sr << 1) | CHAIN_LEN'(w_scan_out);
    end
  end

  assign w_pass = (r_resp_sr == r_exp_ppo_q) && (r_po_q == r_exp_po_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_response <= '0;
      r_pass     <= 1'b0;
    end else if (r_state == COMPARE) begin
      r_response <= r_resp_sr;
      r_pass     <= w_pass;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fail_cnt <= '0;
    else if (clr_count)
      r_fail_cnt <= '0;
    else if ((r_state == COMPARE) && !w_pass && (r_fail_cnt != '1))
      r_fail_cnt <= r_fail_cnt + FAIL_CNT_W'(1);
  end

  // During COMPARE the live result is presented so it is valid with done;
  // the registered copies hold it until the next COMPARE.
  assign pass       = (r_state == COMPARE) ? w_pass    : r_pass;
  assign response   = (r_state == COMPARE) ? r_resp_sr : r_response;
  assign done       = (r_state == COMPARE);
  assign busy       = (r_state != IDLE);
  assign scan_en    = w_scan_en;
  assign ppi        = w_chain;
  assign pi         = r_pi_q;
  assign fail_count = r_fail_cnt;

endmodule

// File: tb/tb_scan_test_ctrl.sv
module tb_scan_test_ctrl;

  localparam int N = 2;
  localparam int DONE_PH = 2 * N + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] pattern = '0;
  logic         pi_value = 1'b0;
  logic [N-1:0] exp_ppo = '0;
  logic         exp_po = 1'b0;
  logic         clr_count = 1'b0;
  logic [N-1:0] ppi;
  logic         pi;
  logic [N-1:0] ppo;
  logic         po;
  logic         scan_en, busy, done, pass;
  logic [N-1:0] response;
  logic [15:0]  fail_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [N-1:0] core_ppo(input logic [N-1:0] s, input logic p);
    return {p & (s[1] | s[0]), ~(s[1] | s[0])};
  endfunction

  function automatic logic core_po(input logic [N-1:0] c);
    return ~(c[1] | c[0]);
  endfunction

  assign ppo = core_ppo(ppi, pi);
  assign po  = core_po(ppo);

  scan_test_ctrl #(.CHAIN_LEN(N), .PI_W(1), .PO_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .pi_value(pi_value), .exp_ppo(exp_ppo), .exp_po(exp_po),
    .clr_count(clr_count), .ppi(ppi), .pi(pi), .ppo(ppo), .po(po),
    .scan_en(scan_en), .busy(busy), .done(done), .pass(pass),
    .response(response), .fail_count(fail_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase = cycles since the accepted start (0 = idle).
  int          m_phase;
  logic [N-1:0] m_pat, m_eppo, m_resp;
  logic         m_pi, m_epo, m_pass;
  logic [15:0]  m_fail;
  logic         preload = 1'b0;
  logic         skip_fc = 1'b0;

  function automatic logic model_pass();
    logic [N-1:0] c;
    c = core_ppo(m_pat, m_pi);
    return (c == m_eppo) && (core_po(c) == m_epo);
  endfunction

  function automatic logic [N-1:0] exp_ppi(input int p);
    logic [N-1:0] cap;
    cap = core_ppo(m_pat, m_pi);
    if (p >= 1 && p <= N)               return m_pat >> (N - (p - 1));
    else if (p == N + 1)                return m_pat;
    else if (p >= N + 2 && p <= 2*N+1)  return cap << (p - N - 2);
    else                                return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_pat <= '0; m_eppo <= '0; m_resp <= '0;
      m_pi <= 1'b0; m_epo <= 1'b0; m_pass <= 1'b0;
      m_fail <= '0;
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_pat <= pattern; m_pi <= pi_value;
          m_eppo <= exp_ppo; m_epo <= exp_po;
          m_phase <= 1;
        end
      end else if (m_phase == DONE_PH) begin
        m_resp  <= core_ppo(m_pat, m_pi);
        m_pass  <= model_pass();
        m_phase <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
      if (clr_count)
        m_fail <= '0;
      else if (preload)
        m_fail <= 16'hFFFE;
      else if (m_phase == DONE_PH && !model_pass() && m_fail != 16'hFFFF)
        m_fail <= m_fail + 16'd1;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_phase != 0);
    chk("scan_en", scan_en, (m_phase >= 1 && m_phase <= N) ||
                            (m_phase >= N + 2 && m_phase <= 2*N+1));
    chk("done", done, m_phase == DONE_PH);
    chk("pi", pi, m_pi);
    chk("ppi", ppi, exp_ppi(m_phase));
    chk("pass", pass, (m_phase == DONE_PH) ? model_pass() : m_pass);
    chk("response", response, (m_phase == DONE_PH) ? core_ppo(m_pat, m_pi) : m_resp);
    if (!skip_fc) chk("fail_count", fail_count, m_fail);
  end

  task automatic run_pattern(input logic [N-1:0] pat, input logic piv,
                             input logic [N-1:0] ep, input logic epo,
                             input logic [N-1:0] xr, input logic xp,
                             input logic clr_at_done, input int pulse_at);
    int k;
    int extra;
    logic got;
    logic [N-1:0] cap_ppi;
    @(negedge clk);
    start = 1'b1; pattern = pat; pi_value = piv; exp_ppo = ep; exp_po = epo;
    k = 0; got = 1'b0; cap_ppi = '0;
    while (k < 20 && !got) begin
      @(negedge clk);
      k++;
      start = (k == pulse_at);
      pattern = ~pat; pi_value = ~piv; exp_ppo = ~ep; exp_po = ~epo;
      if (k == N + 1) cap_ppi = ppi;
      if (done) got = 1'b1;
    end
    chk("latency", k, DONE_PH);
    chk("capture_ppi", cap_ppi, pat);
    chk("lit_response", response, xr);
    chk("lit_pass", pass, xp);
    clr_count = clr_at_done;
    @(negedge clk);
    clr_count = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("extra_done", extra, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ppi", ppi, 0);
    chk("rst_fail", fail_count, 0);
    rst_n = 1'b1;

    run_pattern(2'b00, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 0);
    chk("lit_fc_a", fail_count, 0);
    run_pattern(2'b10, 1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0, 0);
    run_pattern(2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 0);
    chk("lit_fc_b", fail_count, 1);
    run_pattern(2'b10, 1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0, 3);
    chk("lit_fc_c", fail_count, 1);

    // Reset during SHIFT_OUT.
    @(negedge clk);
    start = 1'b1; pattern = 2'b10; pi_value = 1'b1; exp_ppo = 2'b00; exp_po = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_scan_en", scan_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ppi", ppi, 0);
    chk("mid_rst_fail", fail_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_pattern(2'b00, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 0);

    // Saturation: preload near the top, then force failures.
    @(negedge clk);
    skip_fc = 1'b1; preload = 1'b1;
    force dut.r_fail_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_fail_cnt;
    preload = 1'b0;
    @(posedge clk);
    #1 skip_fc = 1'b0;
    run_pattern(2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 0);
    chk("lit_sat_a", fail_count, 16'hFFFF);
    run_pattern(2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 0);
    chk("lit_sat_b", fail_count, 16'hFFFF);
    run_pattern(2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 0);
    chk("lit_clr", fail_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
